ga_chrom_queue: RTL and testbench
=================================

GA_CHROM_QUEUE -- requirements
Module: ga_chrom_queue

Interface
REQ-001 SHALL take parameters from shared ga_params.const: CHROM_MAX_W, default 64, chromosome width (M_MAX x DATA_W).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 16, entries; power of two, range [4,64].
REQ-003 SHALL have parameter P_MAX_W, default 8, width of population-size config.
REQ-004 SHALL derive local parameter QUEUE_CNT_W = log2(QUEUE_DEPTH)+1, default 5; not user-settable.
REQ-005 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-006 SHALL have port sw_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port cnfg_pop_size  in  P_MAX_W  chromosomes per generation.
REQ-008 SHALL have port queue_push  in  1  push strobe from ga_mutation.
REQ-009 SHALL have port queue_chromosome  in  CHROM_MAX_W  push data, valid with queue_push.
REQ-010 SHALL have port queue_almost_full  out  1  count >= QUEUE_DEPTH-2, for upstream throttling.
REQ-011 SHALL have port pop_valid  out  1  head entry available.
REQ-012 SHALL have port pop_chromosome  out  CHROM_MAX_W  head entry data.
REQ-013 SHALL have port pop_ack  in  1  consumer takes head when pop_valid=1.
REQ-014 SHALL have port queue_cnt  out  QUEUE_CNT_W  current occupancy.
REQ-015 SHALL have port gen_done  out  1  one-cycle pulse, generation fully pushed.
REQ-016 SHALL have port err_overflow  out  1  sticky, push dropped while full.
REQ-017 SHALL have port err_underflow  out  1  sticky, pop_ack while empty.

Function
REQ-018 SHALL be a FIFO; circular write/read pointers, log2(QUEUE_DEPTH) bits, wrap from QUEUE_DEPTH-1 to 0.
REQ-019 SHALL accept a push when queue_push=1 and (count<QUEUE_DEPTH or a pop is accepted the same cycle).
REQ-020 SHALL expose accepted push on pop_chromosome/pop_valid at earliest the next cycle (write-to-read latency 1).
REQ-021 SHALL drive pop_valid = (count!=0) and pop_chromosome = entry at read pointer, first-word-fall-through, no extra latency.
REQ-022 SHALL accept a pop when pop_ack=1 and pop_valid=1; read pointer advances next cycle.
REQ-023 Simultaneous push+pop, not full/empty: both accepted, count unchanged.
REQ-024 Simultaneous push+pop while full: both accepted, count stays QUEUE_DEPTH, no overflow.
REQ-025 Simultaneous push+pop while empty: push accepted, pop ignored, err_underflow set.
REQ-026 Push while full without pop: data dropped, pointers unchanged, err_overflow set to 1 until sw_rst.
REQ-027 pop_ack while empty: no state change except err_underflow set to 1 until sw_rst.
REQ-028 SHALL count accepted pushes in gen counter (P_MAX_W bits); when increment reaches cnfg_pop_size, gen_done=1 for the following cycle and counter returns to 0.
REQ-029 cnfg_pop_size=0 SHALL never assert gen_done; counter wraps at 2^P_MAX_W.
REQ-030 Dropped pushes SHALL NOT increment the gen counter.
REQ-031 queue_cnt, queue_almost_full, gen_done, err flags SHALL be registered outputs.

Reset
REQ-032 On sw_rst=1 at posedge: pointers, count, gen counter =0; pop_valid=0, queue_almost_full=0, gen_done=0, err_overflow=0, err_underflow=0, queue_cnt=0.
REQ-033 pop_chromosome after reset SHALL be all zeros (storage cleared or output masked while empty).
REQ-034 sw_rst mid-operation SHALL discard all stored entries and override a simultaneous push/pop.

Structure
REQ-035 CHROM_MAX_W, P_MAX_W, QUEUE_DEPTH, SIM_DLY SHALL live in shared ga_params.const; QUEUE_CNT_W local.
REQ-036 Storage SHALL be a sub-module ga_chrom_queue_ram (1 write, 1 async read port, sw_rst-free); pointer/count/flag control in ga_chrom_queue.

Verification
REQ-037 Reset then push 3 entries A,B,C on consecutive cycles -> pop_valid next cycle after A, pops return A,B,C in order, queue_cnt 0,1,2,3 then down to 0.
REQ-038 Depth 16: push 17 without pop -> queue_cnt=16, queue_almost_full from count 14, 17th dropped, err_overflow=1 sticky.
REQ-039 Full queue, push+pop same cycle -> queue_cnt stays 16, new data appears after 15 further pops, no overflow.
REQ-040 cnfg_pop_size=5, push 12 (pops keep pace) -> gen_done pulses after 5th and 10th accepted push, exactly one cycle each.
REQ-041 Empty queue, pop_ack=1 with push=1 -> push stored, count=1, err_underflow=1.
REQ-042 sw_rst asserted with 7 entries and push active -> next cycle count=0, pop_valid=0, all flags 0, gen counter restarts.

Source files
------------

// File: rtl/ga_chrom_queue_pkg.sv
// ----------------------------------------------------------------------------
// ga_chrom_queue_pkg
// Shared GA constants used by the chromosome queue and its neighbours.
//   CHROM_MAX_W : chromosome width (M_MAX x DATA_W)
//   P_MAX_W     : width of the population-size configuration
//   QUEUE_DEPTH : default queue depth (power of two, 4..64)
//   SIM_DLY     : sampling delay used by simulation models around a clock edge
// cnt_width() gives the occupancy counter width for a given depth. The counter
// needs one bit more than the pointers so that "full" is representable.
// ----------------------------------------------------------------------------
package ga_chrom_queue_pkg;

    localparam int CHROM_MAX_W = 64;
    localparam int P_MAX_W     = 8;
    localparam int QUEUE_DEPTH = 16;
    localparam int SIM_DLY     = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ga_chrom_queue_if.sv
// ----------------------------------------------------------------------------
// ga_chrom_queue_if
// Push/pop/status bundle of the chromosome queue.
//   master : producer + consumer side (drives push and pop_ack)
//   slave  : the queue itself (drives head data, occupancy and flags)
// ----------------------------------------------------------------------------
interface ga_chrom_queue_if #(
    parameter int CHROM_MAX_W = ga_chrom_queue_pkg::CHROM_MAX_W,
    parameter int QUEUE_DEPTH = ga_chrom_queue_pkg::QUEUE_DEPTH
);
    import ga_chrom_queue_pkg::*;

    localparam int QUEUE_CNT_W = cnt_width(QUEUE_DEPTH);

    logic                   queue_push;
    logic [CHROM_MAX_W-1:0] queue_chromosome;
    logic                   queue_almost_full;
    logic                   pop_valid;
    logic [CHROM_MAX_W-1:0] pop_chromosome;
    logic                   pop_ack;
    logic [QUEUE_CNT_W-1:0] queue_cnt;
    logic                   gen_done;
    logic                   err_overflow;
    logic                   err_underflow;

    modport master (
        output queue_push, queue_chromosome, pop_ack,
        input  queue_almost_full, pop_valid, pop_chromosome,
               queue_cnt, gen_done, err_overflow, err_underflow
    );

    modport slave (
        input  queue_push, queue_chromosome, pop_ack,
        output queue_almost_full, pop_valid, pop_chromosome,
               queue_cnt, gen_done, err_overflow, err_underflow
    );

endinterface

// File: rtl/ga_chrom_queue_ram.sv
// ----------------------------------------------------------------------------
// ga_chrom_queue_ram
// Storage array for the chromosome queue: one synchronous write port and one
// asynchronous read port. No reset; the controller masks stale contents.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational from rd_addr_i)
// ----------------------------------------------------------------------------
module ga_chrom_queue_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ga_chrom_queue.sv
// ----------------------------------------------------------------------------
// ga_chrom_queue
// First-word-fall-through FIFO between ga_mutation and the next GA stage, with
// a generation counter that pulses gen_done each time cnfg_pop_size accepted
// pushes have been seen.
//   clk           : clock, all logic on posedge
//   sw_rst        : synchronous active-high reset
//   cnfg_pop_size : chromosomes per generation (0 = never signal gen_done)
//   queue_bus     : push data/strobe, pop data/valid/ack, occupancy, gen_done,
//                   sticky overflow/underflow flags
// ----------------------------------------------------------------------------
module ga_chrom_queue #(
    parameter int CHROM_MAX_W = ga_chrom_queue_pkg::CHROM_MAX_W,
    parameter int QUEUE_DEPTH = ga_chrom_queue_pkg::QUEUE_DEPTH,
    parameter int P_MAX_W     = ga_chrom_queue_pkg::P_MAX_W
) (
    input  logic               clk,
    input  logic               sw_rst,
    input  logic [P_MAX_W-1:0] cnfg_pop_size,
    ga_chrom_queue_if.slave    queue_bus
);
    import ga_chrom_queue_pkg::*;

    localparam int ADDR_W      = $clog2(QUEUE_DEPTH);
    localparam int QUEUE_CNT_W = cnt_width(QUEUE_DEPTH);
    localparam logic [QUEUE_CNT_W-1:0] CNT_FULL  = QUEUE_CNT_W'(QUEUE_DEPTH);
    localparam logic [QUEUE_CNT_W-1:0] CNT_AFULL = QUEUE_CNT_W'(QUEUE_DEPTH - 2);

    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [QUEUE_CNT_W-1:0] cnt_q, cnt_d;
    logic [P_MAX_W-1:0]     gen_cnt_q, gen_cnt_d, gen_inc;
    logic                   afull_q, afull_d;
    logic                   gen_done_q, gen_done_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   empty, full, pop_acc, push_acc;
    logic [CHROM_MAX_W-1:0] ram_rd_data;

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CNT_FULL);
        pop_acc    = queue_bus.pop_ack && !empty;
        // A pop in the same cycle frees the slot, so a full queue still takes the push.
        push_acc   = queue_bus.queue_push && (!full || pop_acc);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        gen_cnt_d  = gen_cnt_q;
        gen_inc    = gen_cnt_q + P_MAX_W'(1);
        gen_done_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        // Pointers wrap naturally at QUEUE_DEPTH (power of two).
        if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({push_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + QUEUE_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - QUEUE_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        afull_d = (cnt_d >= CNT_AFULL);

        // Size 0 never matches, so the counter just wraps at 2^P_MAX_W.
        if (push_acc) begin
            if ((cnfg_pop_size != '0) && (gen_inc == cnfg_pop_size)) begin
                gen_cnt_d  = '0;
                gen_done_d = 1'b1;
            end else begin
                gen_cnt_d  = gen_inc;
            end
        end

        if (queue_bus.queue_push && full && !pop_acc) ovf_d = 1'b1;
        if (queue_bus.pop_ack && empty)               unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            gen_cnt_q  <= '0;
            afull_q    <= 1'b0;
            gen_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            gen_cnt_q  <= gen_cnt_d;
            afull_q    <= afull_d;
            gen_done_q <= gen_done_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Pushes are gated by sw_rst so a reset cycle leaves the array untouched.
    ga_chrom_queue_ram #(
        .DATA_W (CHROM_MAX_W),
        .DEPTH  (QUEUE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push_acc && !sw_rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (queue_bus.queue_chromosome),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    // The array is not reset, so head data is masked to zero while empty.
    assign queue_bus.pop_valid         = !empty;
    assign queue_bus.pop_chromosome    = empty ? '0 : ram_rd_data;
    assign queue_bus.queue_cnt         = cnt_q;
    assign queue_bus.queue_almost_full = afull_q;
    assign queue_bus.gen_done          = gen_done_q;
    assign queue_bus.err_overflow      = ovf_q;
    assign queue_bus.err_underflow     = unf_q;

endmodule

// File: tb/tb_ga_chrom_queue.sv
// ----------------------------------------------------------------------------
// tb_ga_chrom_queue
// Directed bench for ga_chrom_queue (depth 16, 64-bit chromosomes, 8-bit
// population size). Inputs change and outputs are sampled SIM_DLY after each
// rising edge.
// ----------------------------------------------------------------------------
module tb_ga_chrom_queue;
    import ga_chrom_queue_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int PW    = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          sw_rst;
    logic [PW-1:0] cnfg_pop_size;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    ga_chrom_queue_if #(.CHROM_MAX_W(DW), .QUEUE_DEPTH(DEPTH)) qif ();

    ga_chrom_queue #(
        .CHROM_MAX_W (DW),
        .QUEUE_DEPTH (DEPTH),
        .P_MAX_W     (PW)
    ) dut (
        .clk           (clk),
        .sw_rst        (sw_rst),
        .cnfg_pop_size (cnfg_pop_size),
        .queue_bus     (qif)
    );

    task automatic tick(input string tag);
        @(posedge clk);
        #(SIM_DLY);
        $display("[%0t] %s push=%0b ack=%0b cnt=%0d valid=%0b head=%h af=%0b gd=%0b ovf=%0b unf=%0b",
                 $time, tag, qif.queue_push, qif.pop_ack, qif.queue_cnt, qif.pop_valid,
                 qif.pop_chromosome, qif.queue_almost_full, qif.gen_done,
                 qif.err_overflow, qif.err_underflow);
    endtask

    task automatic do_reset();
        sw_rst               = 1'b1;
        qif.queue_push       = 1'b0;
        qif.queue_chromosome = '0;
        qif.pop_ack          = 1'b0;
        tick("reset");
        tick("reset");
        sw_rst = 1'b0;
    endtask

    task automatic test_reset();
        cnfg_pop_size = '0;
        do_reset();
        checks++; if (qif.queue_cnt !== 5'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", qif.queue_cnt); end
        checks++; if (qif.pop_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", qif.pop_valid); end
        checks++; if (qif.pop_chromosome !== 64'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", qif.pop_chromosome); end
        checks++; if (qif.queue_almost_full !== 1'b0) begin failures++; $display("FAIL rst_afull got=%0b exp=0", qif.queue_almost_full); end
        checks++; if (qif.gen_done !== 1'b0) begin failures++; $display("FAIL rst_gen_done got=%0b exp=0", qif.gen_done); end
        checks++; if ({qif.err_overflow, qif.err_underflow} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {qif.err_overflow, qif.err_underflow}); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals [3] = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = vals[i];
            tick("basic_push");
            checks++; if (qif.queue_cnt !== CW'(i + 1)) begin failures++; $display("FAIL basic_push_cnt got=%0d exp=%0d", qif.queue_cnt, i + 1); end
            checks++; if (qif.pop_valid !== 1'b1) begin failures++; $display("FAIL basic_push_valid got=%0b exp=1", qif.pop_valid); end
            checks++; if (qif.pop_chromosome !== vals[0]) begin failures++; $display("FAIL basic_push_head got=%h exp=%h", qif.pop_chromosome, vals[0]); end
        end
        qif.queue_push = 1'b0;
        qif.pop_ack    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] exp_head;
            exp_head = (i < 2) ? vals[i + 1] : 64'd0;
            tick("basic_pop");
            checks++; if (qif.queue_cnt !== CW'(2 - i)) begin failures++; $display("FAIL basic_pop_cnt got=%0d exp=%0d", qif.queue_cnt, 2 - i); end
            checks++; if (qif.pop_valid !== (i < 2)) begin failures++; $display("FAIL basic_pop_valid got=%0b exp=%0b", qif.pop_valid, (i < 2)); end
            checks++; if (qif.pop_chromosome !== exp_head) begin failures++; $display("FAIL basic_pop_head got=%h exp=%h", qif.pop_chromosome, exp_head); end
        end
        qif.pop_ack = 1'b0;
        checks++; if (qif.err_underflow !== 1'b0) begin failures++; $display("FAIL basic_unf got=%0b exp=0", qif.err_underflow); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] base = 64'h0F00_0000_0000_0000;
        int            exp_cnt;
        cnfg_pop_size = '0;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = base + 64'(i);
            tick("ovf_push");
            exp_cnt = (i <= 16) ? i : 16;
            checks++; if (qif.queue_cnt !== CW'(exp_cnt)) begin failures++; $display("FAIL ovf_cnt got=%0d exp=%0d", qif.queue_cnt, exp_cnt); end
            checks++; if (qif.queue_almost_full !== (exp_cnt >= 14)) begin failures++; $display("FAIL ovf_afull at=%0d got=%0b exp=%0b", exp_cnt, qif.queue_almost_full, (exp_cnt >= 14)); end
            checks++; if (qif.err_overflow !== (i == 17)) begin failures++; $display("FAIL ovf_flag push=%0d got=%0b exp=%0b", i, qif.err_overflow, (i == 17)); end
            checks++; if (qif.gen_done !== 1'b0) begin failures++; $display("FAIL ovf_gen_done_size0 got=%0b exp=0", qif.gen_done); end
        end
        qif.queue_push = 1'b0;
        tick("ovf_idle");
        tick("ovf_idle");
        checks++; if (qif.err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", qif.err_overflow); end
        checks++; if (qif.queue_cnt !== 5'd16) begin failures++; $display("FAIL ovf_idle_cnt got=%0d exp=16", qif.queue_cnt); end
        checks++; if (qif.pop_chromosome !== base + 64'd1) begin failures++; $display("FAIL ovf_head got=%h exp=%h", qif.pop_chromosome, base + 64'd1); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] base    = 64'h2200_0000_0000_0000;
        logic [DW-1:0] new_val = 64'hDEAD_BEEF_CAFE_F00D;
        logic [DW-1:0] exp_head;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = base + 64'(i);
            tick("full_fill");
        end
        checks++; if (qif.queue_cnt !== 5'd16) begin failures++; $display("FAIL full_fill_cnt got=%0d exp=16", qif.queue_cnt); end
        qif.queue_chromosome = new_val;
        qif.pop_ack          = 1'b1;
        tick("full_push_pop");
        checks++; if (qif.queue_cnt !== 5'd16) begin failures++; $display("FAIL full_pp_cnt got=%0d exp=16", qif.queue_cnt); end
        checks++; if (qif.err_overflow !== 1'b0) begin failures++; $display("FAIL full_pp_ovf got=%0b exp=0", qif.err_overflow); end
        checks++; if (qif.pop_chromosome !== base + 64'd1) begin failures++; $display("FAIL full_pp_head got=%h exp=%h", qif.pop_chromosome, base + 64'd1); end
        qif.queue_push = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            exp_head = (k < 15) ? base + 64'(k + 1) : new_val;
            tick("full_drain");
            checks++; if (qif.pop_chromosome !== exp_head) begin failures++; $display("FAIL full_drain_head k=%0d got=%h exp=%h", k, qif.pop_chromosome, exp_head); end
            checks++; if (qif.queue_cnt !== CW'(16 - k)) begin failures++; $display("FAIL full_drain_cnt got=%0d exp=%0d", qif.queue_cnt, 16 - k); end
        end
        tick("full_last_pop");
        qif.pop_ack = 1'b0;
        checks++; if (qif.pop_valid !== 1'b0) begin failures++; $display("FAIL full_empty_valid got=%0b exp=0", qif.pop_valid); end
        checks++; if ({qif.err_overflow, qif.err_underflow} !== 2'b00) begin failures++; $display("FAIL full_err got=%b exp=00", {qif.err_overflow, qif.err_underflow}); end
    endtask

    task automatic test_gen_done();
        logic [DW-1:0] base = 64'h5500_0000_0000_0000;
        do_reset();
        cnfg_pop_size = 8'd5;
        for (int i = 1; i <= 12; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = base + 64'(i);
            qif.pop_ack          = (i > 1);
            tick("gen_push");
            checks++; if (qif.gen_done !== (i == 5 || i == 10)) begin failures++; $display("FAIL gen_done push=%0d got=%0b exp=%0b", i, qif.gen_done, (i == 5 || i == 10)); end
            checks++; if (qif.pop_chromosome !== base + 64'(i)) begin failures++; $display("FAIL gen_head push=%0d got=%h exp=%h", i, qif.pop_chromosome, base + 64'(i)); end
            checks++; if (qif.queue_cnt !== 5'd1) begin failures++; $display("FAIL gen_cnt got=%0d exp=1", qif.queue_cnt); end
        end
        qif.queue_push = 1'b0;
        qif.pop_ack    = 1'b0;
        tick("gen_idle");
        checks++; if (qif.gen_done !== 1'b0) begin failures++; $display("FAIL gen_done_idle got=%0b exp=0", qif.gen_done); end
        checks++; if (qif.err_underflow !== 1'b0) begin failures++; $display("FAIL gen_unf got=%0b exp=0", qif.err_underflow); end
        cnfg_pop_size = '0;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] val = 64'h7777_1234_5678_9ABC;
        do_reset();
        qif.queue_push       = 1'b1;
        qif.queue_chromosome = val;
        qif.pop_ack          = 1'b1;
        tick("unf_push_pop");
        checks++; if (qif.queue_cnt !== 5'd1) begin failures++; $display("FAIL unf_cnt got=%0d exp=1", qif.queue_cnt); end
        checks++; if (qif.err_underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%0b exp=1", qif.err_underflow); end
        checks++; if (qif.pop_chromosome !== val) begin failures++; $display("FAIL unf_head got=%h exp=%h", qif.pop_chromosome, val); end
        checks++; if (qif.err_overflow !== 1'b0) begin failures++; $display("FAIL unf_ovf got=%0b exp=0", qif.err_overflow); end
        qif.queue_push = 1'b0;
        tick("unf_pop");
        tick("unf_pop_empty");
        qif.pop_ack = 1'b0;
        tick("unf_idle");
        checks++; if (qif.queue_cnt !== 5'd0) begin failures++; $display("FAIL unf_empty_cnt got=%0d exp=0", qif.queue_cnt); end
        checks++; if (qif.err_underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%0b exp=1", qif.err_underflow); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] base = 64'h9900_0000_0000_0000;
        do_reset();
        cnfg_pop_size = 8'd5;
        qif.pop_ack   = 1'b1;
        tick("mid_unf");
        qif.pop_ack   = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = base + 64'(i);
            tick("mid_push");
            if (i == 5) begin
                checks++; if (qif.gen_done !== 1'b1) begin failures++; $display("FAIL mid_gen_done_pre got=%0b exp=1", qif.gen_done); end
            end
        end
        checks++; if (qif.queue_cnt !== 5'd7) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=7", qif.queue_cnt); end
        sw_rst      = 1'b1;
        qif.pop_ack = 1'b1;
        tick("mid_reset");
        sw_rst      = 1'b0;
        qif.pop_ack = 1'b0;
        qif.queue_push = 1'b0;
        checks++; if (qif.queue_cnt !== 5'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", qif.queue_cnt); end
        checks++; if (qif.pop_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", qif.pop_valid); end
        checks++; if (qif.pop_chromosome !== 64'd0) begin failures++; $display("FAIL mid_data got=%h exp=0", qif.pop_chromosome); end
        checks++; if ({qif.queue_almost_full, qif.gen_done, qif.err_overflow, qif.err_underflow} !== 4'b0000) begin
            failures++; $display("FAIL mid_flags got=%b exp=0000", {qif.queue_almost_full, qif.gen_done, qif.err_overflow, qif.err_underflow});
        end
        for (int i = 1; i <= 5; i++) begin
            qif.queue_push       = 1'b1;
            qif.queue_chromosome = base + 64'(i + 16);
            tick("mid_repush");
            checks++; if (qif.gen_done !== (i == 5)) begin failures++; $display("FAIL mid_gen_restart push=%0d got=%0b exp=%0b", i, qif.gen_done, (i == 5)); end
        end
        qif.queue_push = 1'b0;
        checks++; if (qif.pop_chromosome !== base + 64'd17) begin failures++; $display("FAIL mid_head got=%h exp=%h", qif.pop_chromosome, base + 64'd17); end
        cnfg_pop_size = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        sw_rst               = 1'b1;
        cnfg_pop_size        = '0;
        qif.queue_push       = 1'b0;
        qif.queue_chromosome = '0;
        qif.pop_ack          = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_gen_done();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
